// File: rtl/pkt_dsc_credit_manager_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pkt_dsc_credit_manager_pkg : metadata types and constants for the credit manager
// Rev 1.0
// ---------------------------------------------------------------------------
package pkt_dsc_credit_manager_pkg;

  localparam int PKT_Q_ID_WIDTH          = 16;
  localparam int MAX_DSC_CREDITS_DEFAULT = 4;

  typedef struct packed {
    logic [15:0] head;
    logic [15:0] tail;
  } pkt_q_state_t;

  typedef struct packed {
    logic [PKT_Q_ID_WIDTH-1:0] pkt_queue_id;
    pkt_q_state_t              pkt_q_state;
    logic [15:0]               size;
    logic                      drop_data;
    logic                      descriptor_only;
    logic                      needs_dsc;
    logic                      drop_meta;
  } pkt_meta_with_queues_t;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } credit_state_e;

  // Zero or out-of-range limits fall back to the build-time maximum.
  function automatic int clamp_credit_limit(input int cfg, input int max_credits);
    return (cfg == 0 || cfg > max_credits) ? max_credits : cfg;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pkt_dsc_credit_manager_fwd_window.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dsc_credit_fwd_window : recent (queue, count) decisions with newest-wins match
// Rev 1.0
// ---------------------------------------------------------------------------
module dsc_credit_fwd_window #(
  parameter int DEPTH = 3,
  parameter int QW    = 13,
  parameter int CW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_valid,
  input  logic [QW-1:0] push_qid,
  input  logic [CW-1:0] push_cnt,
  input  logic [QW-1:0] lookup_qid,
  output logic          hit,
  output logic [CW-1:0] fwd_cnt
);

  logic [DEPTH-1:0] r_valid;
  logic [QW-1:0]    r_qid [DEPTH];
  logic [CW-1:0]    r_cnt [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_qid[i] <= '0;
        r_cnt[i] <= '0;
      end
    end else begin
      r_valid[0] <= push_valid;
      r_qid[0]   <= push_qid;
      r_cnt[0]   <= push_cnt;
      for (int i = 1; i < DEPTH; i++) begin
        r_valid[i] <= r_valid[i-1];
        r_qid[i]   <= r_qid[i-1];
        r_cnt[i]   <= r_cnt[i-1];
      end
    end
  end

  // Scan oldest to newest so the most recent decision overrides.
  always_comb begin
    hit     = 1'b0;
    fwd_cnt = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (r_valid[i] && (r_qid[i] == lookup_qid)) begin
        hit     = 1'b1;
        fwd_cnt = r_cnt[i];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/pkt_dsc_credit_manager.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pkt_dsc_credit_manager : per-queue descriptor credit tracking and metadata tagging
// Rev 1.0
// ---------------------------------------------------------------------------
module pkt_dsc_credit_manager
  import pkt_dsc_credit_manager_pkg::*;
#(
  parameter int  NB_QUEUES   = 8192,
  parameter int  MAX_CREDITS = MAX_DSC_CREDITS_DEFAULT,
  parameter int  RD_LATENCY  = 2,
  parameter int  FIFO_DEPTH  = 16,
  localparam int CW          = $clog2(MAX_CREDITS + 1),
  localparam int QW          = $clog2(NB_QUEUES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  pkt_meta_with_queues_t in_meta_data,
  input  logic                  in_meta_valid,
  output logic                  in_meta_ready,
  output pkt_meta_with_queues_t out_meta_data,
  output logic                  out_meta_valid,
  input  logic                  out_meta_ready,
  input  logic [CW-1:0]         cfg_max_credits,
  output logic                  init_done,
  output logic [31:0]           dsc_emitted_cnt,
  output logic [31:0]           dsc_suppressed_cnt,
  output logic [31:0]           credit_underflow_cnt
);

  localparam int LAST = RD_LATENCY - 1;
  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int OW   = $clog2(FIFO_DEPTH + RD_LATENCY + 2);

  credit_state_e r_state, w_state_next;
  logic [QW-1:0] r_init_addr;
  logic          w_init_we;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_INIT;
    else      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_init_we    = 1'b0;
    init_done    = 1'b0;
    case (r_state)
      ST_INIT: begin
        w_init_we = 1'b1;
        if (r_init_addr == QW'(NB_QUEUES - 1)) w_state_next = ST_RUN;
      end
      ST_RUN:  init_done = 1'b1;
      default: w_state_next = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           r_init_addr <= '0;
    else if (w_init_we) r_init_addr <= r_init_addr + QW'(1);
  end

  logic          w_accept;
  logic [QW-1:0] w_in_qid;
  assign w_accept = in_meta_valid && in_meta_ready;
  assign w_in_qid = in_meta_data.pkt_queue_id[PKT_Q_ID_WIDTH-1 -: QW];

  logic [RD_LATENCY-1:0] r_p_valid;
  pkt_meta_with_queues_t r_p_meta [RD_LATENCY];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_p_valid <= '0;
    end else begin
      r_p_valid[0] <= w_accept;
      for (int i = 1; i < RD_LATENCY; i++) r_p_valid[i] <= r_p_valid[i-1];
    end
  end

  always_ff @(posedge clk) begin
    r_p_meta[0] <= in_meta_data;
    for (int i = 1; i < RD_LATENCY; i++) r_p_meta[i] <= r_p_meta[i-1];
  end

  // Credit memory: write-first on address collision, read data delayed to RD_LATENCY.
  logic [CW-1:0] r_mem [NB_QUEUES];
  logic [CW-1:0] r_rd  [RD_LATENCY];
  logic          w_mem_we;
  logic [QW-1:0] w_mem_waddr;
  logic [CW-1:0] w_mem_wdata;

  logic                  r_dec_valid;
  logic [QW-1:0]         r_dec_qid;
  logic [CW-1:0]         r_dec_cnt;
  pkt_meta_with_queues_t r_dec_meta;

  always_comb begin
    w_mem_we    = r_dec_valid;
    w_mem_waddr = r_dec_qid;
    w_mem_wdata = r_dec_cnt;
    if (w_init_we) begin
      w_mem_we    = 1'b1;
      w_mem_waddr = r_init_addr;
      w_mem_wdata = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[w_mem_waddr] <= w_mem_wdata;
    r_rd[0] <= (w_mem_we && (w_mem_waddr == w_in_qid)) ? w_mem_wdata : r_mem[w_in_qid];
    for (int i = 1; i < RD_LATENCY; i++) r_rd[i] <= r_rd[i-1];
  end

  pkt_meta_with_queues_t w_meta, w_out;
  logic [QW-1:0]         w_dec_qid;
  logic [CW-1:0]         w_fwd_cnt, w_cur, w_ret, w_new, w_limit;
  logic                  w_fwd_hit, w_emit, w_supp, w_under;

  assign w_meta    = r_p_meta[LAST];
  assign w_dec_qid = w_meta.pkt_queue_id[PKT_Q_ID_WIDTH-1 -: QW];
  assign w_cur     = w_fwd_hit ? w_fwd_cnt : r_rd[LAST];
  assign w_limit   = CW'(clamp_credit_limit(int'(cfg_max_credits), MAX_CREDITS));
  assign w_ret     = (w_cur == '0) ? '0 : w_cur - CW'(1);

  dsc_credit_fwd_window #(
    .DEPTH (RD_LATENCY + 1),
    .QW    (QW),
    .CW    (CW)
  ) u_fwd_window (
    .clk        (clk),
    .rst        (rst),
    .push_valid (r_p_valid[LAST]),
    .push_qid   (w_dec_qid),
    .push_cnt   (w_new),
    .lookup_qid (w_dec_qid),
    .hit        (w_fwd_hit),
    .fwd_cnt    (w_fwd_cnt)
  );

  always_comb begin
    w_out   = w_meta;
    w_new   = w_cur;
    w_emit  = 1'b0;
    w_supp  = 1'b0;
    w_under = 1'b0;
    if (w_meta.needs_dsc) begin
      // Head update merged with a packet: the descriptor is forced.
      w_out.drop_meta = 1'b0;
      w_new           = (w_cur == '0) ? CW'(1) : w_cur;
    end else if (w_meta.descriptor_only) begin
      w_under = (w_cur == '0);
      if (w_meta.pkt_q_state.head == w_meta.pkt_q_state.tail) begin
        w_out.drop_meta = 1'b1;
        w_out.needs_dsc = 1'b0;
        w_new           = w_ret;
      end else if (w_ret < w_limit) begin
        w_out.drop_meta = 1'b0;
        w_out.needs_dsc = 1'b1;
        w_new           = w_ret + CW'(1);
      end else begin
        w_out.drop_meta = 1'b1;
        w_out.needs_dsc = 1'b0;
        w_new           = w_ret;
      end
    end else if (w_meta.drop_data) begin
      w_out.needs_dsc = 1'b0;
    end else if (w_cur < w_limit) begin
      w_out.needs_dsc = 1'b1;
      w_new           = w_cur + CW'(1);
      w_emit          = 1'b1;
    end else begin
      w_out.needs_dsc = 1'b0;
      w_supp          = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dec_valid          <= 1'b0;
      r_dec_qid            <= '0;
      r_dec_cnt            <= '0;
      r_dec_meta           <= '0;
      dsc_emitted_cnt      <= '0;
      dsc_suppressed_cnt   <= '0;
      credit_underflow_cnt <= '0;
    end else begin
      r_dec_valid <= r_p_valid[LAST];
      r_dec_qid   <= w_dec_qid;
      r_dec_cnt   <= w_new;
      r_dec_meta  <= w_out;
      if (r_p_valid[LAST]) begin
        if (w_emit)  dsc_emitted_cnt      <= dsc_emitted_cnt + 32'd1;
        if (w_supp)  dsc_suppressed_cnt   <= dsc_suppressed_cnt + 32'd1;
        if (w_under) credit_underflow_cnt <= credit_underflow_cnt + 32'd1;
      end
    end
  end

  // Output FIFO; admission reserves room for every beat still in the pipeline.
  pkt_meta_with_queues_t r_fifo [FIFO_DEPTH];
  logic [PW-1:0]         r_wptr, r_rptr;
  logic [OW-1:0]         r_occ, w_inflight;
  logic                  w_pop;

  always_comb begin
    w_inflight = OW'(r_dec_valid);
    for (int i = 0; i < RD_LATENCY; i++) w_inflight = w_inflight + OW'(r_p_valid[i]);
  end

  assign in_meta_ready  = (r_state == ST_RUN) && ((r_occ + w_inflight) < OW'(FIFO_DEPTH));
  assign out_meta_valid = (r_occ != '0);
  assign out_meta_data  = out_meta_valid ? r_fifo[r_rptr] : '0;
  assign w_pop          = out_meta_valid && out_meta_ready;

  always_ff @(posedge clk) begin
    if (r_dec_valid) r_fifo[r_wptr] <= r_dec_meta;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_occ  <= '0;
    end else begin
      if (r_dec_valid) r_wptr <= (r_wptr == PW'(FIFO_DEPTH - 1)) ? '0 : r_wptr + PW'(1);
      if (w_pop)       r_rptr <= (r_rptr == PW'(FIFO_DEPTH - 1)) ? '0 : r_rptr + PW'(1);
      r_occ <= r_occ + OW'(r_dec_valid) - OW'(w_pop);
    end
  end

endmodule
`default_nettype wire
